// File: rtl/user_dma.sv
// user_dma: register-programmed single-outstanding OBI word copy engine.
// Define USER_DMA_IRQ_EN to enable the one-cycle completion interrupt.
package user_dma_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } mgr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_rsp_t;
endpackage

module user_dma
  import user_dma_pkg::*;
#(
  parameter int unsigned LenWidth = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t cfg_obi_req_i,
  output sbr_obi_rsp_t cfg_obi_rsp_o,
  output mgr_obi_req_t user_mgr_obi_req_o,
  input  mgr_obi_rsp_t user_mgr_obi_rsp_i,
  output logic         irq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } state_e;

  state_e state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [31:0] src_cur_q, src_cur_d;
  logic [31:0] dst_cur_q, dst_cur_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [31:0] buf_q, buf_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0] rid_q, rid_d;

  logic busy;
  logic cfg_wr;
  logic ctrl_wr;
  logic fin;
  logic [1:0] off;
  mgr_obi_req_t mreq;

  assign busy = (state_q != S_IDLE);
  assign off = cfg_obi_req_i.addr[3:2];
  assign cfg_wr = cfg_obi_req_i.req & cfg_obi_req_i.we;
  assign ctrl_wr = cfg_wr & (off == 2'd3);

  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    src_cur_d = src_cur_q;
    dst_cur_d = dst_cur_q;
    rem_d = rem_q;
    buf_d = buf_q;
    done_d = done_q;
    err_d = err_q;
    fin = 1'b0;
    mreq = '0;

    if (cfg_wr && !busy) begin
      unique case (off)
        2'd0: src_d = {cfg_obi_req_i.wdata[31:2], 2'b00};
        2'd1: dst_d = {cfg_obi_req_i.wdata[31:2], 2'b00};
        2'd2: len_d = cfg_obi_req_i.wdata[LenWidth-1:0];
        default: ;
      endcase
    end

    if (ctrl_wr && cfg_obi_req_i.wdata[1]) begin
      done_d = 1'b0;
      err_d = 1'b0;
    end

    if (ctrl_wr && cfg_obi_req_i.wdata[0] && !busy) begin
      done_d = 1'b0;
      err_d = 1'b0;
      if (len_q == '0) begin
        done_d = 1'b1;
        fin = 1'b1;
      end else begin
        state_d = S_RD_REQ;
        src_cur_d = src_q;
        dst_cur_d = dst_q;
        rem_d = len_q;
      end
    end

    // Completions are applied last so they win over a same-cycle clear.
    unique case (state_q)
      S_RD_REQ: begin
        mreq.req = 1'b1;
        mreq.be = 4'hF;
        mreq.addr = src_cur_q;
        if (user_mgr_obi_rsp_i.gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (user_mgr_obi_rsp_i.rvalid) begin
          if (user_mgr_obi_rsp_i.err) begin
            err_d = 1'b1;
            done_d = 1'b1;
            fin = 1'b1;
            state_d = S_IDLE;
          end else begin
            buf_d = user_mgr_obi_rsp_i.rdata;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        mreq.req = 1'b1;
        mreq.we = 1'b1;
        mreq.be = 4'hF;
        mreq.addr = dst_cur_q;
        mreq.wdata = buf_q;
        if (user_mgr_obi_rsp_i.gnt) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (user_mgr_obi_rsp_i.rvalid) begin
          if (user_mgr_obi_rsp_i.err) begin
            err_d = 1'b1;
            done_d = 1'b1;
            fin = 1'b1;
            state_d = S_IDLE;
          end else begin
            src_cur_d = src_cur_q + 32'd4;
            dst_cur_d = dst_cur_q + 32'd4;
            rem_d = rem_q - LenWidth'(1);
            if (rem_q == LenWidth'(1)) begin
              done_d = 1'b1;
              fin = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rvalid_d = cfg_obi_req_i.req;
    rid_d = cfg_obi_req_i.aid;
    rdata_d = '0;
    if (cfg_obi_req_i.req && !cfg_obi_req_i.we) begin
      unique case (off)
        2'd0: rdata_d = src_q;
        2'd1: rdata_d = dst_q;
        2'd2: rdata_d = 32'(len_q);
        default: rdata_d = {29'b0, err_q, done_q, busy};
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      src_cur_q <= '0;
      dst_cur_q <= '0;
      rem_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rid_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      src_cur_q <= src_cur_d;
      dst_cur_q <= dst_cur_d;
      rem_q <= rem_d;
      buf_q <= buf_d;
      done_q <= done_d;
      err_q <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rid_q <= rid_d;
    end
  end

  assign cfg_obi_rsp_o.gnt = cfg_obi_req_i.req;
  assign cfg_obi_rsp_o.rvalid = rvalid_q;
  assign cfg_obi_rsp_o.rdata = rdata_q;
  assign cfg_obi_rsp_o.err = 1'b0;
  assign cfg_obi_rsp_o.rid = rid_q;

  assign user_mgr_obi_req_o = mreq;

`ifdef USER_DMA_IRQ_EN
  // fin marks the completion cycle; done is visible one cycle later
  // and the interrupt follows one cycle after that.
  logic fin_q;
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fin_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      fin_q <= fin;
      irq_q <= fin_q;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_fin;
  assign unused_fin = fin;
  assign irq_o = 1'b0;
`endif

  logic unused_cfg;
  assign unused_cfg = ^{cfg_obi_req_i.be,
                        cfg_obi_req_i.addr[31:4],
                        cfg_obi_req_i.addr[1:0]};

endmodule

// File: tb/tb_user_dma.sv
// tb_user_dma: directed and randomized copy transfers against a memory
// responder and a transaction-list reference model.
module tb_user_dma;
  import user_dma_pkg::*;

`ifdef USER_DMA_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sbr_obi_req_t creq;
  sbr_obi_rsp_t crsp;
  mgr_obi_req_t mreq;
  mgr_obi_rsp_t mrsp = '0;
  logic irq;

  always #5 clk = ~clk;

  user_dma #(.LenWidth(16)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cfg_obi_req_i(creq),
    .cfg_obi_rsp_o(crsp),
    .user_mgr_obi_req_o(mreq),
    .user_mgr_obi_rsp_i(mrsp),
    .irq_o(irq)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        stable;
  } txn_t;

  txn_t txlog[$];
  logic [31:0] mem [logic [31:0]];

  int force_stall = -1;
  bit rand_stall = 0;
  bit hold_wr = 0;
  int err_txn = -1;
  int n_txn = 0;
  int viol = 0;
  int irq_hi = 0;
  int req_cyc = 0;
  int base_g = 0;

  bit pend_v = 0;
  bit pend_we = 0;
  bit pend_err = 0;
  logic [31:0] pend_data;
  bit in_req = 0;
  int stall_tgt = 0;
  int stall_cnt = 0;
  mgr_obi_req_t first;
  logic stab;

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  always @(negedge clk) begin
    mrsp = '0;
    if (irq) irq_hi++;
    if (mreq.req) req_cyc++;
    if (mreq.req && pend_v) viol++;
    if (pend_v && !(pend_we && hold_wr)) begin
      mrsp.rvalid = 1'b1;
      mrsp.rdata = pend_data;
      mrsp.err = pend_err;
      pend_v = 0;
    end
    if (mreq.req) begin
      if (!in_req) begin
        in_req = 1;
        stall_cnt = 0;
        first = mreq;
        stab = 1'b1;
        if (force_stall >= 0) begin
          stall_tgt = force_stall;
          force_stall = -1;
        end else begin
          stall_tgt = rand_stall ? int'($urandom_range(0, 3)) : 0;
        end
      end else if (mreq !== first) begin
        stab = 1'b0;
      end
      if (stall_cnt == stall_tgt) begin
        mrsp.gnt = 1'b1;
        in_req = 0;
        txlog.push_back('{mreq.we, mreq.addr, mreq.wdata, stall_cnt, stab});
        pend_v = 1;
        pend_we = mreq.we;
        pend_err = (n_txn == err_txn);
        pend_data = mreq.we ? 32'h0 : rd(mreq.addr);
        if (mreq.we && !pend_err) mem[mreq.addr] = mreq.wdata;
        n_txn++;
      end else begin
        stall_cnt++;
      end
    end
  end

  task automatic cfg_acc(input logic we, input int off,
                         input logic [31:0] wd, output logic [31:0] rd_o);
    logic [3:0] id;
    id = 4'($urandom);
    @(negedge clk);
    creq = '0;
    creq.req = 1'b1;
    creq.we = we;
    creq.be = 4'hF;
    creq.addr = 32'h4000_0000 | 32'(off << 2);
    creq.wdata = wd;
    creq.aid = id;
    #1;
    chk("cfg_gnt", crsp.gnt === 1'b1);
    @(negedge clk);
    creq = '0;
    chk("cfg_rvalid", crsp.rvalid === 1'b1);
    chk("cfg_rid", crsp.rid === id);
    chk("cfg_err", crsp.err === 1'b0);
    rd_o = crsp.rdata;
  endtask

  task automatic cfg_wr(input int off, input logic [31:0] wd);
    logic [31:0] d;
    cfg_acc(1'b1, off, wd, d);
  endtask

  task automatic cfg_rd(input int off, input logic [31:0] ev, input string tag);
    logic [31:0] d;
    cfg_acc(1'b0, off, 32'h0, d);
    chk(tag, d === ev);
  endtask

  task automatic prog_start(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int errt);
    for (int i = 0; i < len; i++) mem[src + 32'(4 * i)] = $urandom;
    base_g = txlog.size();
    err_txn = (errt < 0) ? -1 : n_txn + errt;
    irq_hi = 0;
    viol = 0;
    cfg_wr(0, src | 32'h3);
    cfg_wr(1, dst | 32'h1);
    cfg_wr(2, 32'(len));
    cfg_wr(3, 32'h1);
  endtask

  task automatic finish_chk(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int errt, input string tag);
    logic [31:0] s;
    int nexp;
    int nwr;
    s = 32'h1;
    for (int k = 0; k < 300 && s[0]; k++) cfg_acc(1'b0, 3, 32'h0, s);
    chk({tag, "_idle"}, s[0] === 1'b0);
    repeat (4) @(negedge clk);
    nexp = (errt < 0) ? 2 * len : errt + 1;
    nwr = (errt < 0) ? len : errt / 2;
    chk({tag, "_ntxn"}, (txlog.size() - base_g) === nexp);
    for (int i = 0; i < nexp && base_g + i < txlog.size(); i++) begin
      int w;
      txn_t t;
      w = i / 2;
      t = txlog[base_g + i];
      chk({tag, "_we"}, t.we === logic'(i % 2));
      chk({tag, "_addr"},
          t.addr === (((i % 2) ? dst : src) + 32'(4 * w)));
      if (i % 2)
        chk({tag, "_wdata"}, t.wdata === rd(src + 32'(4 * w)));
      chk({tag, "_stable"}, t.stable === 1'b1);
    end
    for (int w = 0; w < nwr; w++)
      chk({tag, "_dst"},
          rd(dst + 32'(4 * w)) === rd(src + 32'(4 * w)));
    cfg_rd(3, (errt < 0) ? 32'h2 : 32'h6, {tag, "_status"});
    chk({tag, "_outstanding"}, viol === 0);
    chk({tag, "_irq"}, irq_hi === IRQ_EXP);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d;
    int len, errt, n0, rc, k;
    creq = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mreq", mreq.req === 1'b0);
    chk("rst_rvalid", crsp.rvalid === 1'b0);
    chk("rst_irq", irq === 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_mreq", mreq.req === 1'b0);
    cfg_rd(3, 32'h0, "rst_status");
    cfg_rd(0, 32'h0, "rst_src");
    cfg_rd(2, 32'h0, "rst_len");

    cfg_wr(0, 32'h1234_5677);
    cfg_rd(0, 32'h1234_5674, "src_mask");
    cfg_wr(1, 32'hABCD_EF02);
    cfg_rd(1, 32'hABCD_EF00, "dst_mask");
    cfg_wr(2, 32'hFFFF_0005);
    cfg_rd(2, 32'h0000_0005, "len_mask");

    force_stall = 5;
    prog_start(32'h1000_0000, 32'h1000_0100, 3, -1);
    finish_chk(32'h1000_0000, 32'h1000_0100, 3, -1, "norm");
    chk("bp_stall", txlog[base_g].stall === 5);
    cfg_wr(3, 32'h2);
    cfg_rd(3, 32'h0, "clr_status");

    prog_start(32'h1100_0000, 32'h1100_0100, 4, 2);
    finish_chk(32'h1100_0000, 32'h1100_0100, 4, 2, "err");
    cfg_wr(3, 32'h2);

    base_g = txlog.size();
    irq_hi = 0;
    rc = req_cyc;
    cfg_wr(2, 32'h0);
    cfg_wr(3, 32'h1);
    cfg_rd(3, 32'h2, "zl_status");
    repeat (4) @(negedge clk);
    chk("zl_ntxn", (txlog.size() - base_g) === 0);
    chk("zl_req", (req_cyc - rc) === 0);
    chk("zl_irq", irq_hi === IRQ_EXP);

    force_stall = 10;
    prog_start(32'h2000_0000, 32'h2000_0800, 3, -1);
    cfg_wr(1, 32'hFFFF_FFF0);
    cfg_wr(3, 32'h1);
    cfg_rd(1, 32'h2000_0800, "busy_dst");
    finish_chk(32'h2000_0000, 32'h2000_0800, 3, -1, "busy");

    prog_start(32'hFFFF_FFF8, 32'h0000_0100, 3, -1);
    finish_chk(32'hFFFF_FFF8, 32'h0000_0100, 3, -1, "wrap");

    rand_stall = 1;
    for (int r = 0; r < 6; r++) begin
      logic [31:0] sa, da;
      sa = 32'h4000_0000 + 32'(r << 8) + 32'($urandom_range(0, 15) << 2);
      da = 32'h5000_0000 + 32'(r << 8) + 32'($urandom_range(0, 15) << 2);
      len = $urandom_range(1, 6);
      errt = ($urandom_range(0, 2) == 0) ?
             int'($urandom_range(0, 2 * len - 1)) : -1;
      prog_start(sa, da, len, errt);
      finish_chk(sa, da, len, errt, "rand");
      cfg_wr(3, 32'h2);
    end
    rand_stall = 0;

    hold_wr = 1;
    prog_start(32'h3000_0000, 32'h3000_0400, 3, -1);
    k = 0;
    while (txlog.size() < base_g + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rmid_reach_wr", (txlog.size() >= base_g + 2) === 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmid_req", mreq.req === 1'b0);
    hold_wr = 0;
    rc = req_cyc;
    n0 = txlog.size();
    repeat (10) @(negedge clk);
    chk("rmid_noreq", (req_cyc - rc) === 0);
    chk("rmid_ntxn", (txlog.size() - n0) === 0);
    cfg_rd(3, 32'h0, "rmid_status");
    cfg_rd(0, 32'h0, "rmid_src");
    cfg_rd(1, 32'h0, "rmid_dst");
    cfg_rd(2, 32'h0, "rmid_len");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/user_dma.md
USER_DMA -- requirements
Module: user_dma

Interface
REQ-001 SHALL have parameter LenWidth, default 16, meaning the width of the transfer word-count register.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port cfg_obi_req_i, input, sbr_obi_req_t, the register-access subordinate request.
REQ-005 SHALL have port cfg_obi_rsp_o, output, sbr_obi_rsp_t, the register-access subordinate response.
REQ-006 SHALL have port user_mgr_obi_req_o, output, mgr_obi_req_t, the copy-engine manager request.
REQ-007 SHALL have port user_mgr_obi_rsp_i, input, mgr_obi_rsp_t, the copy-engine manager response.
REQ-008 SHALL have port irq_o, output, 1, the completion interrupt.

Function
REQ-009 SHALL decode register offsets from addr[3:2]: 0 SRC, 1 DST, 2 LEN (LenWidth bits, word count), 3 CTRL/STATUS.
REQ-010 SHALL grant every cfg request in the same cycle and assert rvalid exactly one cycle later, echoing aid, with err=0.
REQ-011 SHALL return STATUS on reads of offset 3 as {29'b0, err, done, busy}; unused LEN bits SHALL read as 0.
REQ-012 SHALL ignore cfg writes to SRC, DST and LEN while busy=1, and SHALL force SRC/DST bits [1:0] to 0.
REQ-013 SHALL treat a CTRL write with wdata[0]=1 while idle as start, which clears done and err and enters RD_REQ; when busy=1 the start SHALL be ignored.
REQ-014 SHALL treat a CTRL write with wdata[1]=1 as clearing done and err; on a simultaneous completion the clear SHALL lose.
REQ-015 SHALL complete a start with LEN=0 immediately: done=1 one cycle after the write, with no manager request issued.
REQ-016 SHALL implement the FSM IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT, then back to RD_REQ while remaining>0, otherwise to IDLE.
REQ-017 SHALL, in RD_REQ, drive req=1, we=0, be=4'hF, addr=src_cur, and hold all request fields stable until gnt.
REQ-018 SHALL, in RD_WAIT, capture rdata into a 32-bit buffer on rvalid.
REQ-019 SHALL, in WR_REQ, drive req=1, we=1, be=4'hF, addr=dst_cur, wdata=buffer, held stable until gnt.
REQ-020 SHALL, on write rvalid, add 4 to src_cur and dst_cur (32-bit wrap-around permitted) and decrement remaining.
REQ-021 SHALL keep at most one manager transaction outstanding, with req deasserted in both WAIT states.
REQ-022 SHALL, on rvalid with err=1 in either WAIT state, set err=1 and done=1, go to IDLE, and not issue the write.
REQ-023 SHALL hold busy=1 in every state except IDLE.

Reset
REQ-024 SHALL, when rst_ni=0 at a clock edge, clear SRC, DST, LEN, the buffer, done, err and remaining, and set the FSM to IDLE.
REQ-025 SHALL hold all outputs at 0 during and after reset until new activity: mgr req=0, cfg rvalid=0, irq_o=0.
REQ-026 SHALL, on reset mid-transfer, abandon the transfer with no further manager request and ignore any late rvalid.

Configuration
REQ-027 SHALL, with USER_DMA_IRQ_EN defined, pulse irq_o high for exactly one cycle in the cycle after done rises, including on an error completion.
REQ-028 SHALL, without USER_DMA_IRQ_EN, tie irq_o to 0 and leave all other behaviour unchanged.

Verification
REQ-029 SHALL cover a normal transfer: SRC=0x1000_0000, DST=0x1000_0100, LEN=3, start -> 3 reads then 3 writes alternating at incrementing addresses, destination words equal source words, then STATUS=0x2.
REQ-030 SHALL cover back-pressure: gnt withheld 5 cycles on the first read -> req, addr and we stable for all 5 cycles, with exactly one transaction.
REQ-031 SHALL cover an error completion: an err=1 response on the 2nd read of LEN=4 -> no 2nd write, STATUS=0x6, and a single irq_o pulse when USER_DMA_IRQ_EN is defined.
REQ-032 SHALL cover a zero-length transfer: LEN=0 then start -> no manager req, and STATUS=0x2 on the next read.
REQ-033 SHALL cover writes while busy: writing DST=0xFFFF_FFF0 and start mid-transfer -> both ignored and the original transfer completes unchanged.
REQ-034 SHALL cover reset mid-transfer: rst_ni=0 in WR_WAIT, then a response rvalid arrives -> STATUS=0x0, no req, and SRC/DST/LEN read 0.
